ham_15_11_rx_deserializer: RTL and testbench
============================================

Name: ham_15_11_rx_deserializer

Overview:
- Receive-side front end that sits directly upstream of ham_15_11_decoder.
- Collects a serial channel bitstream, framed by a start-of-frame strobe, into 15-bit Hamming(15,11) codewords.
- Buffers completed codewords in a small FIFO and presents them to the decoder input with a valid/ready handshake.

Parameters:
- CW_W, 15, codeword width in bits; the decoder expects 15.
- FIFO_DEPTH, 2, number of completed codewords buffered; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sin  in  1  serial channel bit.
- sin_vld  in  1  sin is valid this cycle.
- sof  in  1  start of frame; meaningful only when sin_vld=1; marks the first bit of a codeword.
- cw_out  out  CW_W  head codeword; drives the decoder cin.
- cw_vld  out  1  cw_out holds a valid codeword.
- cw_rdy  in  1  downstream accepts cw_out this cycle.
- ovf  out  1  one-cycle pulse: a completed codeword was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse: sof arrived while a frame was partially assembled.

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE, bit counter=0, shift register=0, FIFO empty.
  - cw_out=0, cw_vld=0, ovf=0, frame_err=0.
- Bit order: first bit of a frame lands in cw_out[14], last bit in cw_out[0], i.e. MSB first. cw_out[i] is Hamming position i+1.
- FSM states: IDLE, SHIFT.
  - IDLE: a bit with sin_vld=1 and sof=0 is ignored. sin_vld=1 and sof=1 loads the bit, sets cnt=1 and moves to SHIFT.
  - SHIFT: each sin_vld=1 shifts sin in and increments cnt. When the 15th bit is accepted, the word is completed, cnt clears and the FSM returns to IDLE.
  - SHIFT with sin_vld=0: hold; there is no timeout.
  - SHIFT with sin_vld=1 and sof=1: pulse frame_err and discard the partial word. This bit becomes bit 1 of a new frame (cnt=1), and the FSM stays in SHIFT.
- Completion:
  - FIFO not full: the word is written and appears at the head with cw_vld=1 on the cycle after the 15th bit.
  - FIFO full: the word is dropped and ovf pulses on the next cycle.
  - A simultaneous pop (cw_vld and cw_rdy) in the completion cycle frees a slot, so the write succeeds and ovf stays 0.
- Handshake:
  - Pop occurs when cw_vld and cw_rdy are both 1.
  - cw_out and cw_vld are stable while cw_vld=1 and cw_rdy=0.
  - cw_out holds its last value when the FIFO is empty; it is don't-care but must not be X after reset.
- Throughput: the minimum frame is 15 cycles, so FIFO_DEPTH=2 absorbs up to 30 cycles of cw_rdy=0 without loss.
- Occupancy counter is log2(FIFO_DEPTH)+1 bits; read and write pointers wrap modulo FIFO_DEPTH.
- rst_n asserted mid-frame or with a non-empty FIFO discards everything; there is no partial output.

Optional Feature:
- Macro: HAM_RX_SYNDROME_EN.
- Defined:
  - Adds output syn_out[3:0], the XOR of (i+1) over all set bits cw_out[i].
  - Computed combinationally on the completed word, stored in the FIFO alongside it, and valid with cw_vld.
  - Reset value 0.
- Undefined: the port and its storage are absent; all other behaviour is identical.

Decomposition:
- Shared package ham_pkg holds:
  - CW_W=15, DATA_W=11, SYN_W=4.
  - FSM state typedef rx_state_t {IDLE, SHIFT}.
  - The syndrome function, shared with the decoder.
- One sub-module: ham_cw_fifo (parameterised depth and width, valid/ready pop, registered head).

Test Plan:
- Reset then frame 15'b110101100000011 (sof on first bit, sin_vld continuous) -> cw_vld=1 one cycle after the 15th bit, cw_out=15'h6B03. With HAM_RX_SYNDROME_EN: syn_out=4'hD.
- Three back-to-back frames 15'h6B03, 15'h71C3, 15'h6753 with cw_rdy=0 -> first two buffered, third drops with a single ovf pulse. Then cw_rdy=1 -> 6B03 then 71C3 are popped, and cw_vld falls.
- sof reasserted on the 8th bit of a frame -> frame_err pulses once. The next 15 bits starting at that sof form the output word, and no word is produced from the aborted prefix.
- sin_vld=1 with sof=0 while IDLE for 20 cycles -> no cw_vld, no error pulses. Gaps (sin_vld=0) inside a frame -> word is still assembled correctly.
- FIFO full with cw_rdy=1 in the same cycle the 15th bit of a new frame arrives -> no ovf, and the word is queued behind the remaining entry.
- rst_n pulsed low asynchronously mid-frame with one word queued -> cw_vld=0 immediately. After release, a fresh frame is decoded correctly.

Source files
------------

// File: rtl/ham_pkg.sv
// Shared Hamming(15,11) definitions: widths, receive FSM state type and the
// syndrome function also used by ham_15_11_decoder.
package ham_pkg;

    localparam int CW_W   = 15;
    localparam int DATA_W = 11;
    localparam int SYN_W  = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    // XOR of Hamming positions (i+1) for every set bit cw[i]
    function automatic logic [SYN_W-1:0] ham_syndrome(input logic [CW_W-1:0] cw);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int i = 0; i < CW_W; i++) begin
            if (cw[i]) s = s ^ SYN_W'(i + 1);
        end
        return s;
    endfunction

endpackage

// File: rtl/ham_cw_fifo.sv
// Small codeword FIFO with a registered head entry and valid/ready pop.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module ham_cw_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             drop,
    output logic [WIDTH-1:0] head,
    output logic             head_vld,
    input  logic             head_rdy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr, wptr, rptr_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             pop, full, push_ok;

    always_comb begin
        pop       = head_vld & head_rdy;
        full      = (count == CNT_W'(DEPTH));
        push_ok   = push & (~full | pop);
        drop      = push & ~push_ok;
        rptr_nxt  = pop ? rptr + AW'(1) : rptr;
        count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end

    // Head is refreshed from the entry that will sit at rptr after this edge,
    // bypassing the array when that entry is being written right now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            head     <= '0;
            head_vld <= 1'b0;
        end else begin
            rptr     <= rptr_nxt;
            count    <= count_nxt;
            head_vld <= (count_nxt != '0);
            if (push_ok) wptr <= wptr + AW'(1);
            if (count_nxt != '0)
                head <= (push_ok && (wptr == rptr_nxt)) ? wdata : mem[rptr_nxt];
        end
    end

endmodule

// File: rtl/ham_15_11_rx_deserializer.sv
// Serial-to-parallel front end for ham_15_11_decoder: MSB-first framing on sof,
// codeword FIFO, valid/ready output. Define HAM_RX_SYNDROME_EN to add syn_out.
module ham_15_11_rx_deserializer
    import ham_pkg::*;
#(
    parameter int CW_W       = 15,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sin,
    input  logic            sin_vld,
    input  logic            sof,
    output logic [CW_W-1:0] cw_out,
    output logic            cw_vld,
    input  logic            cw_rdy,
    output logic            ovf,
`ifdef HAM_RX_SYNDROME_EN
    output logic [3:0]      syn_out,
`endif
    output logic            frame_err
);

    localparam int CNT_W = $clog2(CW_W);

    rx_state_t         state, state_nxt;
    logic [CW_W-2:0]   shreg_p0;
    logic [CNT_W-1:0]  cnt_p0;
    logic              load, shift_en, done, ferr, drop;
    logic [CW_W-1:0]   word_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sin_vld && sof) state_nxt = SHIFT;
            SHIFT:   if (sin_vld && !sof && cnt_p0 == CNT_W'(CW_W - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load     = sin_vld & sof;
        ferr     = (state == SHIFT) & sin_vld & sof;
        shift_en = (state == SHIFT) & sin_vld & ~sof;
        done     = shift_en & (cnt_p0 == CNT_W'(CW_W - 1));
        word_p0  = {shreg_p0, sin};
    end

    // Stage p0: bit assembly; a completed word goes straight into the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_p0  <= '0;
            cnt_p0    <= '0;
            ovf       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ovf       <= drop;
            frame_err <= ferr;
            if (load) begin
                shreg_p0 <= {{(CW_W-2){1'b0}}, sin};
                cnt_p0   <= CNT_W'(1);
            end else if (done) begin
                shreg_p0 <= '0;
                cnt_p0   <= '0;
            end else if (shift_en) begin
                shreg_p0 <= {shreg_p0[CW_W-3:0], sin};
                cnt_p0   <= cnt_p0 + CNT_W'(1);
            end
        end
    end

`ifdef HAM_RX_SYNDROME_EN
    logic [CW_W+3:0] fifo_head;

    ham_cw_fifo #(.WIDTH(CW_W + 4), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (done),
        .wdata    ({ham_syndrome(word_p0), word_p0}),
        .drop     (drop),
        .head     (fifo_head),
        .head_vld (cw_vld),
        .head_rdy (cw_rdy)
    );

    assign cw_out  = fifo_head[CW_W-1:0];
    assign syn_out = fifo_head[CW_W+3:CW_W];
`else
    ham_cw_fifo #(.WIDTH(CW_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (done),
        .wdata    (word_p0),
        .drop     (drop),
        .head     (cw_out),
        .head_vld (cw_vld),
        .head_rdy (cw_rdy)
    );
`endif

endmodule

// File: tb/tb_ham_15_11_rx_deserializer.sv
// Directed bench for ham_15_11_rx_deserializer with a queue-based reference
// model of the two-entry codeword FIFO.
module tb_ham_15_11_rx_deserializer;

    logic        clk = 1'b0;
    logic        rst_n, sin, sin_vld, sof, cw_rdy;
    logic [14:0] cw_out;
    logic        cw_vld, ovf, frame_err;
`ifdef HAM_RX_SYNDROME_EN
    logic [3:0]  syn_out;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [14:0] q[$];

    always #5 clk = ~clk;

    ham_15_11_rx_deserializer #(.CW_W(15), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .sin_vld   (sin_vld),
        .sof       (sof),
        .cw_out    (cw_out),
        .cw_vld    (cw_vld),
        .cw_rdy    (cw_rdy),
        .ovf       (ovf),
`ifdef HAM_RX_SYNDROME_EN
        .syn_out   (syn_out),
`endif
        .frame_err (frame_err)
    );

    function automatic logic [3:0] syn_of(input logic [14:0] w);
        logic [3:0] s;
        s = 4'h0;
        for (int i = 0; i < 15; i++) if (w[i]) s = s ^ 4'(i + 1);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: check head against the model, apply pop/push, then check pulses.
    task automatic tick(input bit done, input logic [14:0] w, input bit ferr_e);
        bit ovf_e;
        chk("cw_vld", {15'b0, cw_vld}, {15'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk("cw_out", {1'b0, cw_out}, {1'b0, q[0]});
`ifdef HAM_RX_SYNDROME_EN
            chk("syn_out", {12'b0, syn_out}, {12'b0, syn_of(q[0])});
`endif
            if (cw_rdy) void'(q.pop_front());
        end
        ovf_e = 1'b0;
        if (done) begin
            if (q.size() < 2) q.push_back(w);
            else              ovf_e = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("ovf", {15'b0, ovf}, {15'b0, ovf_e});
        chk("frame_err", {15'b0, frame_err}, {15'b0, ferr_e});
    endtask

    task automatic send_frame(input logic [14:0] w, input int nbits, input bit gaps,
                              input bit abort_first, input bit rdy_last);
        for (int i = 0; i < nbits; i++) begin
            if (gaps) begin
                sin_vld = 1'b0;
                sin     = 1'($urandom_range(0, 1));
                sof     = 1'($urandom_range(0, 1));
                tick(1'b0, w, 1'b0);
            end
            if (rdy_last && i == 14) cw_rdy = 1'b1;
            sin     = w[14-i];
            sin_vld = 1'b1;
            sof     = (i == 0);
            tick(i == 14, w, abort_first && i == 0);
        end
        sin_vld = 1'b0;
        sof     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; sin = 1'b0; sin_vld = 1'b0; sof = 1'b0; cw_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cw_vld", {15'b0, cw_vld}, 16'h0);
        chk("rst_cw_out", {1'b0, cw_out}, 16'h0);
        chk("rst_ovf", {15'b0, ovf}, 16'h0);
        chk("rst_frame_err", {15'b0, frame_err}, 16'h0);
`ifdef HAM_RX_SYNDROME_EN
        chk("rst_syn_out", {12'b0, syn_out}, 16'h0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame, bit pattern 110101100000011
        send_frame(15'h6B03, 15, 1'b0, 1'b0, 1'b0);
        chk("t1_vld", {15'b0, cw_vld}, 16'h1);
        chk("t1_word", {1'b0, cw_out}, 16'h6B03);
`ifdef HAM_RX_SYNDROME_EN
        chk("t1_syn", {12'b0, syn_out}, 16'hD);
`endif
        cw_rdy = 1'b1;
        tick(1'b0, 15'h0, 1'b0);
        cw_rdy = 1'b0;
        tick(1'b0, 15'h0, 1'b0);

        // Three back-to-back frames into a stalled two-entry FIFO
        send_frame(15'h6B03, 15, 1'b0, 1'b0, 1'b0);
        send_frame(15'h71C3, 15, 1'b0, 1'b0, 1'b0);
        send_frame(15'h6753, 15, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 15'h0, 1'b0);
        cw_rdy = 1'b1;
        chk("t2_head0", {1'b0, cw_out}, 16'h6B03);
        tick(1'b0, 15'h0, 1'b0);
        chk("t2_head1", {1'b0, cw_out}, 16'h71C3);
        repeat (2) tick(1'b0, 15'h0, 1'b0);

        // sof on the 8th bit aborts the partial frame
        send_frame(15'h2AAA, 7, 1'b0, 1'b0, 1'b0);
        send_frame(15'h71C3, 15, 1'b0, 1'b1, 1'b0);
        chk("t3_word", {1'b0, cw_out}, 16'h71C3);
        repeat (2) tick(1'b0, 15'h0, 1'b0);

        // Valid bits without sof while idle are ignored
        sof = 1'b0;
        repeat (20) begin
            sin_vld = 1'b1;
            sin     = 1'($urandom_range(0, 1));
            tick(1'b0, 15'h0, 1'b0);
        end
        sin_vld = 1'b0;

        // Gaps inside a frame
        send_frame(15'h5A5A, 15, 1'b1, 1'b0, 1'b0);
        repeat (2) tick(1'b0, 15'h0, 1'b0);

        // FIFO full, pop in the completion cycle
        cw_rdy = 1'b0;
        send_frame(15'h6B03, 15, 1'b0, 1'b0, 1'b0);
        send_frame(15'h6753, 15, 1'b0, 1'b0, 1'b0);
        send_frame(15'h71C3, 15, 1'b0, 1'b0, 1'b1);
        cw_rdy = 1'b0;
        chk("t6_head", {1'b0, cw_out}, 16'h6753);
        tick(1'b0, 15'h0, 1'b0);
        cw_rdy = 1'b1;
        repeat (3) tick(1'b0, 15'h0, 1'b0);

        // Asynchronous reset mid-frame with one word queued
        cw_rdy = 1'b0;
        send_frame(15'h71C3, 15, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 15'h0, 1'b0);
        send_frame(15'h6B03, 6, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_vld_async", {15'b0, cw_vld}, 16'h0);
        chk("t7_out_async", {1'b0, cw_out}, 16'h0);
        q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cw_rdy = 1'b1;
        send_frame(15'h6753, 15, 1'b0, 1'b0, 1'b0);
        chk("t7_word", {1'b0, cw_out}, 16'h6753);
        repeat (2) tick(1'b0, 15'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
